// File: rtl/io_input.sv
// Memory-mapped 8-bit input port: synchronized, per-bit debounced pins with sticky
// rising-edge capture, interrupt mask and a fixed two-cycle read latency.
module io_input #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] dataIn,
    output logic        readValid,
    output logic [31:0] dataOut,
    input  logic [7:0]  ioIn,
    output logic        irq
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_EDGE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;

    logic            read_q;
    logic            write_q;
    logic [1:0]      addr_q;
    logic [7:0]      data_in_q;

    logic [7:0]      sync1_q;
    logic [7:0]      sync2_q;
    logic [7:0]      stable_q, stable_d;
    logic [7:0][7:0] cnt_q, cnt_d;
    logic [7:0]      edge_flags_q, edge_flags_d;
    logic [7:0]      mask_q, mask_d;

    logic            read_valid_q;
    logic [7:0]      data_out_q;

    logic [7:0]      rise;
    logic [7:0]      edge_clr;
    logic [7:0]      rd_data;
    logic            unused_data_hi;

    assign unused_data_hi = ^dataIn[31:8];

    // Bus front end: requests are registered, so everything downstream sees them one cycle late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 2'd0;
        end else begin
            read_q  <= read;
            write_q <= write;
            addr_q  <= address;
        end
    end

    always_ff @(posedge clk) begin
        data_in_q <= dataIn[7:0];
    end

    // A bit only moves once it has disagreed with the filtered value for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Set is applied after clear so a rising edge wins over a simultaneous W1C.
    assign rise         = stable_d & ~stable_q;
    assign edge_clr     = (write_q && addr_q == ADDR_EDGE) ? data_in_q : 8'h00;
    assign edge_flags_d = (edge_flags_q & ~edge_clr) | rise;
    assign mask_d       = (write_q && addr_q == ADDR_MASK) ? data_in_q : mask_q;

    always_comb begin
        rd_data = sync2_q;
        case (addr_q)
            ADDR_STATE: rd_data = stable_q;
            ADDR_EDGE:  rd_data = edge_flags_q;
            ADDR_MASK:  rd_data = mask_q;
            default:    rd_data = sync2_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 8'h00;
            sync2_q      <= 8'h00;
            stable_q     <= 8'h00;
            cnt_q        <= '0;
            edge_flags_q <= 8'h00;
            mask_q       <= 8'h00;
            read_valid_q <= 1'b0;
            data_out_q   <= 8'h00;
        end else begin
            sync1_q      <= ioIn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            edge_flags_q <= edge_flags_d;
            mask_q       <= mask_d;
            read_valid_q <= read_q;
            if (read_q) begin
                data_out_q <= rd_data;
            end
        end
    end

    assign readValid = read_valid_q;
    assign dataOut   = {24'h000000, data_out_q};
    assign irq       = |(edge_flags_q & mask_q);

endmodule

// File: doc/io_input.md
# io_input

Memory-mapped 8-bit input port: the receive-side companion to the existing 8-bit output port, on the same single-cycle read/write peripheral bus. External pins are synchronized, debounced per bit, and rising edges are latched into a sticky capture register with a maskable interrupt. Software reads pin state and captured edges through a 2-bit register address, with the same fixed two-cycle read latency as the other IO peripherals.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized bit must differ from its debounced value before that value updates. Legal range is 1..255.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- read  in  1  one-cycle read request
- write  in  1  one-cycle write request
- address  in  2  register select, sampled with read/write
- dataIn  in  32  write data; only [7:0] used
- readValid  out  1  one-cycle pulse; dataOut valid this cycle
- dataOut  out  32  read data; [31:8] always 0
- ioIn  in  8  asynchronous external pins
- irq  out  1  level interrupt, high while any (edge & mask) bit is set

## Operation
- Register map:
  - 0 STATE (RO): debounced pin value.
  - 1 EDGE (R/W1C): sticky rising-edge flags.
  - 2 MASK (RW): interrupt enables.
  - 3 RAW (RO): synchronized, undebounced pins.
  - Writes to 0 and 3 are ignored.
- Bus front end: read, write, address and dataIn[7:0] are registered every cycle into readReg, writeReg, addrReg and dataInReg; the control flops are reset.
- Synchronizer: a 2-flop chain per bit (sync1, then sync2). RAW = sync2.
- Debounce, per bit, with an 8-bit counter cnt:
  - if sync2 == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0.
  - else: cnt <= cnt+1.
  - A single-cycle agreement with stable restarts the count.
- Edge capture: the EDGE bit sets on the clock edge where stable goes 0->1. Falling edges are not captured.
- EDGE write (writeReg && addrReg==1): clears the bits where dataInReg is 1.
  - If a set and a clear hit the same bit on the same edge, set wins.
- MASK write (writeReg && addrReg==2): MASK <= dataInReg.
- irq = |(EDGE & MASK), decoded combinationally from registers. It deasserts the cycle after the last contributing bit is cleared or masked.
- Reset values:
  - sync1, sync2, stable, cnt, EDGE, MASK: 0.
  - readValid, dataOut, irq: 0.
  - A pin held high through reset therefore produces one rising edge after release.

## Timing
- Read request in cycle N:
  - readReg and addrReg load at edge N+1.
  - At edge N+2: dataOut <= {24'b0, reg[addrReg]} and readValid <= readReg.
  - readValid is high for exactly cycle N+2.
- Writes commit at edge N+2.
  - A read and a write accepted in the same cycle return the pre-write value.
  - Back-to-back requests every cycle are fully pipelined; there is no stall or backpressure.
- Pin to STATE: a pin change settled before edge k reaches sync2 at edge k+1. stable updates at edge k+1+DEBOUNCE_CYCLES; the EDGE bit sets on that same edge.
- Pin to irq: irq is first high in the cycle after edge k+1+DEBOUNCE_CYCLES (given MASK set).
- Pin to readable: a read issued in the first cycle after the EDGE bit sets sees it.
- Reset asserted mid-operation clears everything immediately, including in-flight reads. No readValid is produced for a read whose readReg stage was reset.

## Test plan
- Reset/idle:
  - Assert reset with ioIn=8'h00, then release.
  - Read addr 0..3: each readValid comes exactly 2 cycles after read, with dataOut=0. irq=0.
- Debounce filter (DEBOUNCE_CYCLES=4):
  - Pulse ioIn[0] high for 3 cycles: STATE stays 0 and EDGE stays 0.
  - Hold it high for 4+ cycles: STATE=8'h01 at edge k+5, and EDGE[0] sets.
- Edge/irq/W1C:
  - Write MASK=8'h01. Raise ioIn[0]: irq rises. Read EDGE returns 8'h01.
  - Write 8'h01 to addr 1: irq falls; EDGE reads 0.
  - Lower the pin: no new EDGE bit.
- Set-vs-clear collision: time a W1C of EDGE[2] to commit on the same edge stable[2] rises. EDGE[2] must read 1 afterward.
- Pipelining: issue reads on 4 consecutive cycles to addr 0,1,2,3 with ioIn=8'hA5 stable and MASK=8'h3C. The bench sees 4 consecutive readValid pulses returning 8'hA5, 8'hA5, 8'h3C, 8'hA5 (EDGE=8'hA5 after reset-release edges).
- Reset mid-read: assert reset one cycle after read. readValid never pulses and dataOut=0.
